// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request scheduler: FSM encoding and
// default word width / engine timeout.
package cordic_pkg;

    localparam int W_DEF       = 18;
    localparam int TIMEOUT_DEF = 31;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win
// last time is granted; a lone request is always granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/cordic_sched.sv
// Arbitrates two requesters onto one external CORDIC engine, issues the
// angle, waits for completion (with timeout) and returns the result.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int W       = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req_theta0,
    input  logic [W-1:0] req_theta1,
    input  logic [1:0]   req_cos,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic         eng_start,
    output logic [W-1:0] eng_theta,
    output logic         eng_cos,
    input  logic [W-1:0] eng_result,
    input  logic         eng_done
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic          last_gnt;
    logic          id;
    logic [CW-1:0] cnt;
    logic [1:0]    gnt;

    rr_arb2 u_arb (
        .req  (req_valid),
        .last (last_gnt),
        .gnt  (gnt)
    );

    // rst gate keeps req_ready low while reset is held, even though the
    // FSM is already back in IDLE.
    assign req_ready = (state == ST_IDLE && clk_en && !rst) ? gnt : 2'b00;
    assign rsp_valid = (state == ST_RESP) ? (id ? 2'b10 : 2'b01) : 2'b00;
    assign eng_start = (state == ST_ISSUE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_gnt  <= 1'b1;
            id        <= 1'b0;
            cnt       <= '0;
            eng_theta <= '0;
            eng_cos   <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        eng_theta <= gnt[1] ? req_theta1 : req_theta0;
                        eng_cos   <= req_cos[gnt[1]];
                        id        <= gnt[1];
                        last_gnt  <= gnt[1];
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion wins over a timeout landing on the same edge.
                    if (eng_done) begin
                        rsp_data <= eng_result;
                        rsp_err  <= 1'b0;
                        state    <= ST_RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[id])
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sched.sv
// Randomized transaction-level bench for cordic_sched with a stand-in engine
// and a reference model predicting grant, result, error flag and latency.
module tb_cordic_sched;

    localparam int W     = 18;
    localparam int TMO   = 31;
    localparam int NEVER = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_en;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req_theta0;
    logic [W-1:0] req_theta1;
    logic [1:0]   req_cos;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic         eng_start;
    logic [W-1:0] eng_theta;
    logic         eng_cos;
    logic [W-1:0] eng_result;
    logic         eng_done;

    logic         eng_busy;
    logic         eng_done_m;
    logic         stray_done;
    int           eng_rem;
    int           eng_lat;

    int errs   = 0;
    int checks = 0;
    int last_gnt;
    int gnt_log[$];

    always #5 clk = ~clk;

    assign eng_done = eng_done_m | stray_done;

    cordic_sched dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_theta0 (req_theta0),
        .req_theta1 (req_theta1),
        .req_cos    (req_cos),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_theta  (eng_theta),
        .eng_cos    (eng_cos),
        .eng_result (eng_result),
        .eng_done   (eng_done)
    );

    // Crude small-angle stand-in: sin ~ theta, cos ~ 1 - theta/16.
    function automatic logic [W-1:0] ref_f(input logic [W-1:0] th, input logic c);
        logic [W-1:0] q;
        q = {{4{th[W-1]}}, th[W-1:4]};
        return c ? (18'h10000 - q) : th;
    endfunction

    function automatic logic [1:0] oh(input int i);
        return (i != 0) ? 2'b10 : 2'b01;
    endfunction

    // Engine: done arrives eng_lat active cycles after the issue edge.
    always @(negedge clk) begin
        if (rst) begin
            eng_busy   <= 1'b0;
            eng_done_m <= 1'b0;
        end else if (clk_en) begin
            eng_done_m <= 1'b0;
            if (eng_busy) begin
                if (eng_rem == 0) begin
                    eng_done_m <= 1'b1;
                    eng_busy   <= 1'b0;
                end else begin
                    eng_rem <= eng_rem - 1;
                end
            end
            if (eng_start && eng_lat != NEVER) begin
                eng_busy   <= 1'b1;
                eng_rem    <= eng_lat;
                eng_result <= ref_f(eng_theta, eng_cos);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [1:0] v, input logic [W-1:0] t0, input logic [W-1:0] t1,
                       input logic [1:0] c, input int lat, input bit tog, input int dly);
        int id, n, guard, starts, exp_n;
        logic [W-1:0] th, expd;
        logic ex_err;
        bit ok;
        id = (v == 2'b11) ? ((last_gnt != 0) ? 0 : 1) : (v[1] ? 1 : 0);
        last_gnt = id;
        gnt_log.push_back(id);
        th = (id != 0) ? t1 : t0;
        if (lat + 1 <= TMO) begin
            expd = ref_f(th, c[id]); ex_err = 1'b0; exp_n = lat + 2;
        end else begin
            expd = '0; ex_err = 1'b1; exp_n = TMO + 1;
        end
        req_valid = v; req_theta0 = t0; req_theta1 = t1; req_cos = c;
        eng_lat = lat; clk_en = 1'b1;
        #1;
        chk("grant", 32'(req_ready), 32'(oh(id)));
        step();
        n = 0; guard = 0; starts = 0; ok = 1;
        while (rsp_valid == 2'b00 && guard < 400) begin
            if (eng_theta !== th || eng_cos !== c[id]) ok = 0;
            clk_en = tog ? 1'($urandom_range(0, 1)) : 1'b1;
            if (clk_en && eng_start) starts++;
            step();
            guard++;
            if (clk_en) n++;
        end
        chk("eng_hold", 32'(ok), 32'd1);
        chk("starts", 32'(starts), 32'd1);
        chk("latency", 32'(n), 32'(exp_n));
        chk("rsp_valid", 32'(rsp_valid), 32'(oh(id)));
        chk("rsp_data", 32'(rsp_data), 32'(expd));
        chk("rsp_err", 32'(rsp_err), 32'(ex_err));
        ok = 1;
        for (int i = 0; i < dly; i++) begin
            clk_en = tog ? 1'($urandom_range(0, 1)) : 1'b1;
            rsp_ready = oh(1 - id);
            #1;
            if (req_ready !== 2'b00) ok = 0;
            step();
            if (rsp_valid !== oh(id) || rsp_data !== expd || rsp_err !== ex_err) ok = 0;
        end
        if (dly > 0) chk("rsp_hold", 32'(ok), 32'd1);
        rsp_ready = oh(id);
        clk_en = 1'b1;
        step();
        rsp_ready = 2'b00;
        chk("release", 32'(rsp_valid), 32'd0);
        req_valid = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rv;
        int r, lat;
        rst = 1'b1; clk_en = 1'b1; req_valid = 2'b11; req_theta0 = '0; req_theta1 = '0;
        req_cos = 2'b00; rsp_ready = 2'b00; stray_done = 1'b0; eng_lat = NEVER;
        eng_result = '0; last_gnt = 1;
        step(); step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_eng_start", 32'(eng_start), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_eng_theta", 32'(eng_theta), 32'd0);
        rst = 1'b0; req_valid = 2'b01; clk_en = 1'b0;
        #1;
        chk("ready_gated", 32'(req_ready), 32'd0);
        step(); step();
        req_valid = 2'b00; clk_en = 1'b1;
        step();
        chk("dropped_req", 32'(eng_start), 32'd0);
        stray_done = 1'b1;
        step(); step();
        stray_done = 1'b0;
        chk("stray_idle", 32'(rsp_valid), 32'd0);

        // Contended requests: grants alternate starting with requester 0.
        for (int k = 0; k < 4; k++)
            txn(2'b11, 18'(k * 1000 + 7), 18'(k * 900 + 3000), 2'($urandom_range(0, 3)), 2 + k, 1'b0, 0);
        for (int k = 0; k < 4; k++)
            chk("rr_order", 32'(gnt_log[k]), 32'(k % 2));

        txn(2'b01, 18'h00000, 18'h01234, 2'b11, 5, 1'b0, 0);
        txn(2'b10, 18'h00100, 18'h02000, 2'b00, NEVER, 1'b0, 0);
        txn(2'b01, 18'h00321, 18'h00000, 2'b01, TMO - 1, 1'b0, 0);
        txn(2'b10, 18'h00000, 18'h3F000, 2'b10, TMO - 2, 1'b0, 0);
        txn(2'b01, 18'h00400, 18'h00000, 2'b00, TMO, 1'b0, 1);
        txn(2'b01, 18'h01000, 18'h00000, 2'b01, 6, 1'b0, 10);
        txn(2'b01, 18'h01000, 18'h00000, 2'b01, 6, 1'b1, 3);
        txn(2'b10, 18'h00000, 18'h02222, 2'b10, NEVER, 1'b1, 2);

        for (int k = 0; k < 16; k++) begin
            rv = 2'($urandom_range(1, 3));
            r = $urandom_range(0, 9);
            lat = (r < 7) ? $urandom_range(0, 8) : ((r < 9) ? $urandom_range(25, 35) : NEVER);
            txn(rv, 18'($urandom), 18'($urandom), 2'($urandom_range(0, 3)), lat,
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Reset while waiting on an engine that never answers.
        req_valid = 2'b10; req_theta1 = 18'h0ABCD; req_cos = 2'b10; eng_lat = NEVER; clk_en = 1'b1;
        step(); step(); step(); step();
        req_valid = 2'b00;
        chk("pre_rst_theta", 32'(eng_theta), 32'h0ABCD);
        rst = 1'b1;
        #1;
        chk("async_eng_theta", 32'(eng_theta), 32'd0);
        chk("async_eng_cos", 32'(eng_cos), 32'd0);
        chk("async_eng_start", 32'(eng_start), 32'd0);
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rsp_data", 32'(rsp_data), 32'd0);
        chk("async_rsp_err", 32'(rsp_err), 32'd0);
        last_gnt = 1;
        step();
        rst = 1'b0; stray_done = 1'b1;
        step(); step(); step();
        stray_done = 1'b0;
        chk("late_done_valid", 32'(rsp_valid), 32'd0);
        chk("late_done_start", 32'(eng_start), 32'd0);
        txn(2'b11, 18'h00050, 18'h00060, 2'b01, 4, 1'b0, 1);
        chk("post_rst_grant", 32'(gnt_log[gnt_log.size() - 1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cordic_sched.md
CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 31: maximum clk_en cycles spent waiting for eng_done before the request is aborted.
REQ-002 SHALL have parameter W, default 18: width of angle and result words, signed Q2.16.
REQ-003 SHALL have port clk  input  1  the single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port clk_en  input  1  advance enable; state and registers change only when clk_en=1.
REQ-006 SHALL have port req_valid  input  2  per-requester request strobe.
REQ-007 SHALL have port req_ready  output  2  per-requester accept; at most one bit high.
REQ-008 SHALL have port req_theta0 / req_theta1  input  W each  angle from requester 0 / 1.
REQ-009 SHALL have port req_cos  input  2  per requester: 1 = cosine, 0 = sine.
REQ-010 SHALL have port rsp_valid  output  2  per-requester result valid; at most one bit high.
REQ-011 SHALL have port rsp_ready  input  2  per-requester result accept.
REQ-012 SHALL have port rsp_data  output  W  result word, shared by both requesters.
REQ-013 SHALL have port rsp_err  output  1  timeout flag; qualified by rsp_valid.
REQ-014 SHALL have port eng_start  output  1  start strobe to the shared engine.
REQ-015 SHALL have port eng_theta  output  W  angle to the engine.
REQ-016 SHALL have port eng_cos  output  1  function select to the engine.
REQ-017 SHALL have port eng_result  input  W  engine output word.
REQ-018 SHALL have port eng_done  input  1  engine completion pulse.

Function
REQ-019 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; every transition SHALL occur only on an edge where clk_en=1.
REQ-020 IDLE: when any req_valid bit is high, SHALL drive req_ready for the granted requester only, combinationally gated by clk_en.
REQ-021 IDLE, on the accept edge: SHALL latch theta, cos and the requester id, and SHALL move to ISSUE.
REQ-022 Arbitration SHALL be round-robin; on a simultaneous request the grant SHALL go to the requester not granted last; last-grant SHALL update on each accept.
REQ-023 ISSUE: eng_start=1 for exactly that state; the FSM then moves to WAIT.
REQ-024 eng_theta and eng_cos SHALL be registered and held stable from entry to ISSUE until the FSM returns to IDLE.
REQ-025 WAIT: on clk_en with eng_done=1, SHALL capture eng_result into rsp_data, clear rsp_err and move to RESP.
REQ-026 WAIT: a cycle counter SHALL count clk_en cycles; when it reaches TIMEOUT without eng_done, SHALL set rsp_data=0 and rsp_err=1 and move to RESP.
REQ-027 eng_done arriving on the same edge as the timeout SHALL take priority, giving a normal result.
REQ-028 RESP: rsp_valid[id]=1 and rsp_data held until rsp_ready[id]=1 on a clk_en edge, then IDLE; rsp_ready of the other requester SHALL be ignored.
REQ-029 RESP SHALL last at least one cycle, so the engine's post-done recovery cycle has elapsed before the next eng_start.
REQ-030 eng_done outside WAIT SHALL be ignored.
REQ-031 req_valid may drop before acceptance without effect; requests SHALL NOT be queued.
REQ-032 Latency SHALL be: accept edge, +1 edge ISSUE, engine time, +0 edges to RESP on the eng_done edge; rsp_valid is visible in the cycle after eng_done.

Reset
REQ-033 On rst=1, asynchronously: state=IDLE, last-grant=1 (requester 0 wins first), counter=0, eng_start=0, eng_theta=0, eng_cos=0, rsp_data=0, rsp_err=0, rsp_valid=0, req_ready=0.
REQ-034 Reset mid-operation SHALL abandon the in-flight request with no response; the engine shares rst.

Structure
REQ-035 Shared package cordic_pkg SHALL hold the FSM state encoding, default W, and TIMEOUT.
REQ-036 Round-robin grant logic SHALL be the sub-module rr_arb2 (2 requests, last-grant in, one-hot grant out).
REQ-037 The engine SHALL be external and connected via the eng_* ports; it is not instantiated inside this block.

Verification
REQ-038 Single request, theta=0x00000, cos=1, with the engine model -> eng_start one cycle, rsp_valid[0]=1, rsp_data≈0x10000, rsp_err=0.
REQ-039 req_valid=2'b11 held, four transactions -> grants in order 0,1,0,1, with no eng_start overlapping WAIT.
REQ-040 Engine never asserts eng_done, TIMEOUT=31 -> RESP after 31 clk_en cycles in WAIT, with rsp_data=0, rsp_err=1.
REQ-041 clk_en toggling 1/0 during WAIT -> result identical to clk_en=1, and latency in clk_en cycles unchanged.
REQ-042 rsp_ready held 0 for 10 cycles in RESP, then 1 -> rsp_data stable throughout, new accept only after the release.
REQ-043 rst pulsed in WAIT -> all outputs take reset values immediately (async), and a late eng_done is ignored.
